// File: rtl/pipe_mux_pkg.sv
// Shared types and constants for the registered N:1 word multiplexer.
package pipe_mux_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle for pipe_mux_n; Q_Parity exists only with PIPE_MUX_PARITY_EN.
interface pipe_mux_n_if
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4
) ();

  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] In_Data;
  logic [SEL_W-1:0]        Select;
  logic                    In_Valid;
  logic                    In_Ready;
  logic [WIDTH-1:0]        Q;
  logic                    Q_Valid;
  logic                    Q_Ready;
  logic                    Sel_Err;

`ifdef PIPE_MUX_PARITY_EN
  logic                    Q_Parity;

  modport slave  (input  In_Data, Select, In_Valid, Q_Ready,
                  output In_Ready, Q, Q_Valid, Sel_Err, Q_Parity);
  modport master (output In_Data, Select, In_Valid, Q_Ready,
                  input  In_Ready, Q, Q_Valid, Sel_Err, Q_Parity);
`else
  modport slave  (input  In_Data, Select, In_Valid, Q_Ready,
                  output In_Ready, Q, Q_Valid, Sel_Err);
  modport master (output In_Data, Select, In_Valid, Q_Ready,
                  input  In_Ready, Q, Q_Valid, Sel_Err);
`endif

endinterface

// File: rtl/mux_sel_n.sv
// Combinational indexed word select; out-of-range codes give zero and raise err_o.
module mux_sel_n #(
  parameter int  WIDTH  = 32,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        word_o,
  output logic                    err_o
);

  // Indexed select with range guard.
  always_comb begin
    word_o = '0;
    err_o  = 1'b1;
    if (int'(sel_i) < NUM_IN) begin
      word_o = data_i[int'(sel_i)*WIDTH +: WIDTH];
      err_o  = 1'b0;
    end else begin
      word_o = '0;
      err_o  = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N:1 word mux with 2-entry skid buffer and registered In_Ready.
// Optional Q_Parity output when PIPE_MUX_PARITY_EN is defined.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  pipe_mux_n_if.slave bus
);

`ifdef PIPE_MUX_PARITY_EN
  localparam int ENT_W = WIDTH + 2;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`else
  localparam int ENT_W = WIDTH + 1;
`endif

  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic [ENT_W-1:0] new_ent;
  logic [ENT_W-1:0] q_ent_q, q_ent_d;
  logic [ENT_W-1:0] skid_ent_q, skid_ent_d;
  occ_e             state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             q_valid_q, q_valid_d;
  logic             accept;
  logic             emit;

  mux_sel_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .data_i (bus.In_Data),
    .sel_i  (bus.Select),
    .word_o (mux_word),
    .err_o  (mux_err)
  );

  // Each buffered entry carries {parity?, err, word} so all fields move together.
`ifdef PIPE_MUX_PARITY_EN
  assign new_ent = {even_parity(mux_word), mux_err, mux_word};
`else
  assign new_ent = {mux_err, mux_word};
`endif

  assign accept = bus.In_Valid && in_ready_q;
  assign emit   = q_valid_q && bus.Q_Ready;

  // Occupancy next state and entry movement between Q and the skid slot.
  always_comb begin
    state_d    = state_q;
    q_ent_d    = q_ent_q;
    skid_ent_d = skid_ent_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          q_ent_d = new_ent;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept && emit) begin
          q_ent_d = new_ent;
          state_d = ONE;
        end else if (accept) begin
          skid_ent_d = new_ent;
          state_d    = TWO;
        end else if (emit) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (emit) begin
          q_ent_d = skid_ent_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d = (state_d != TWO);
    q_valid_d  = (state_d != EMPTY);
  end

  // State and datapath registers; In_Ready stays low until the first edge after reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= EMPTY;
      q_ent_q    <= '0;
      skid_ent_q <= '0;
      in_ready_q <= 1'b0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_ent_q    <= q_ent_d;
      skid_ent_q <= skid_ent_d;
      in_ready_q <= in_ready_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign bus.In_Ready = in_ready_q;
  assign bus.Q_Valid  = q_valid_q;
  assign bus.Q        = q_ent_q[WIDTH-1:0];
  assign bus.Sel_Err  = q_ent_q[WIDTH];
`ifdef PIPE_MUX_PARITY_EN
  assign bus.Q_Parity = q_ent_q[WIDTH+1];
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: directed vector table, corner sequences and a queue-based reference model.
module tb_pipe_mux_n;

  typedef struct {
    logic [1:0]  sel;
    logic        v;
    logic        r;
    logic        exp_valid;
    logic [31:0] exp_q;
    logic        exp_err;
    logic        exp_rdy;
  } vec_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  pipe_mux_n_if #(.WIDTH(32), .NUM_IN(4)) b4 ();
  pipe_mux_n_if #(.WIDTH(32), .NUM_IN(3)) b3 ();

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) u4 (.Clk(Clk), .Reset(Reset), .bus(b4));
  pipe_mux_n #(.WIDTH(32), .NUM_IN(3)) u3 (.Clk(Clk), .Reset(Reset), .bus(b3));

  int checks = 0;
  int errors = 0;

  // Reference model: each queue holds {err, word} entries in delivery order, capacity 2.
  logic [32:0] m4[$];
  logic [32:0] m3[$];
  bit          rdy_ok = 1'b0;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_pick(input logic [127:0] data, input int sel, input int n);
    if (sel < n) return {1'b0, data[sel*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  task automatic cmp_model();
    chk("m4_in_ready", 32'(b4.In_Ready), 32'(rdy_ok && (m4.size() < 2)));
    chk("m4_q_valid",  32'(b4.Q_Valid),  32'(m4.size() > 0));
    if (m4.size() > 0) begin
      chk("m4_q",       b4.Q,               m4[0][31:0]);
      chk("m4_sel_err", 32'(b4.Sel_Err),    32'(m4[0][32]));
`ifdef PIPE_MUX_PARITY_EN
      chk("m4_parity",  32'(b4.Q_Parity),   32'(^m4[0][31:0]));
`endif
    end
    chk("m3_in_ready", 32'(b3.In_Ready), 32'(rdy_ok && (m3.size() < 2)));
    chk("m3_q_valid",  32'(b3.Q_Valid),  32'(m3.size() > 0));
    if (m3.size() > 0) begin
      chk("m3_q",       b3.Q,               m3[0][31:0]);
      chk("m3_sel_err", 32'(b3.Sel_Err),    32'(m3[0][32]));
    end
  endtask

  // One clock: predict transfers from pre-edge inputs, advance, then compare at the falling edge.
  task automatic tick();
    bit          a4, e4, a3, e3;
    logic [32:0] n4, n3;
    e4 = (m4.size() > 0) && b4.Q_Ready;
    a4 = b4.In_Valid && rdy_ok && (m4.size() < 2);
    e3 = (m3.size() > 0) && b3.Q_Ready;
    a3 = b3.In_Valid && rdy_ok && (m3.size() < 2);
    n4 = ref_pick(b4.In_Data, int'(b4.Select), 4);
    n3 = ref_pick({32'h0, b3.In_Data}, int'(b3.Select), 3);
    @(posedge Clk);
    if (!Reset) begin
      if (e4) void'(m4.pop_front());
      if (a4) m4.push_back(n4);
      if (e3) void'(m3.pop_front());
      if (a3) m3.push_back(n3);
      rdy_ok = 1'b1;
    end
    @(negedge Clk);
    cmp_model();
  endtask

  task automatic apply_reset_async();
    Reset = 1'b1;
    m4.delete();
    m3.delete();
    rdy_ok = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[1]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b1};
    tbl[2]  = '{2'd1, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b1};
    tbl[3]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[4]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1};
    tbl[5]  = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    tbl[6]  = '{2'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1};
    tbl[7]  = '{2'd3, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0};
    tbl[8]  = '{2'd0, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1};
    tbl[10] = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};

    b4.In_Data  = {32'h12345678, 32'hA5A5A5A5, 32'h22222222, 32'h11111111};
    b4.Select   = 2'd0;
    b4.In_Valid = 1'b0;
    b4.Q_Ready  = 1'b1;
    b3.In_Data  = {32'hA5A5A5A5, 32'h22222222, 32'h11111111};
    b3.Select   = 2'd0;
    b3.In_Valid = 1'b0;
    b3.Q_Ready  = 1'b1;

    // Reset state
    #1;
    chk("rst_q",        b4.Q,                32'h0);
    chk("rst_q_valid",  32'(b4.Q_Valid),     32'h0);
    chk("rst_sel_err",  32'(b4.Sel_Err),     32'h0);
    chk("rst_in_ready", 32'(b4.In_Ready),    32'h0);
    chk("rst3_in_ready", 32'(b3.In_Ready),   32'h0);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    #1 chk("rdy_before_edge", 32'(b4.In_Ready), 32'h0);
    tick();
    chk("rdy_after_release", 32'(b4.In_Ready), 32'h1);

    // Directed table: basic select, stream, backpressure
    for (int i = 0; i < 11; i++) begin
      b4.Select   = tbl[i].sel;
      b4.In_Valid = tbl[i].v;
      b4.Q_Ready  = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(b4.Q_Valid),  32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_ready", i), 32'(b4.In_Ready), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_q", i),   b4.Q,              tbl[i].exp_q);
        chk($sformatf("tbl%0d_err", i), 32'(b4.Sel_Err),   32'(tbl[i].exp_err));
      end
    end

    // Out-of-range select on the 3-input instance
    b3.Select = 2'd3; b3.In_Valid = 1'b1; b3.Q_Ready = 1'b1;
    tick();
    chk("oor_valid", 32'(b3.Q_Valid), 32'h1);
    chk("oor_q",     b3.Q,            32'h0);
    chk("oor_err",   32'(b3.Sel_Err), 32'h1);
    b3.Select = 2'd0;
    tick();
    chk("oor_next_q",   b3.Q,            32'h11111111);
    chk("oor_next_err", 32'(b3.Sel_Err), 32'h0);
    b3.In_Valid = 1'b0;
    tick();

`ifdef PIPE_MUX_PARITY_EN
    b4.In_Data  = {32'h0, 32'h0, 32'h00000003, 32'h00000007};
    b4.Select   = 2'd0; b4.In_Valid = 1'b1; b4.Q_Ready = 1'b1;
    tick();
    chk("par_7", 32'(b4.Q_Parity), 32'h1);
    b4.Select   = 2'd1;
    tick();
    chk("par_3", 32'(b4.Q_Parity), 32'h0);
    b4.In_Valid = 1'b0;
    tick();
`endif

    // Randomised traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      b4.In_Data  = {$urandom, $urandom, $urandom, $urandom};
      b4.Select   = 2'($urandom_range(0, 3));
      b4.In_Valid = ($urandom_range(0, 3) != 0);
      b4.Q_Ready  = ($urandom_range(0, 3) != 0);
      b3.In_Data  = {$urandom, $urandom, $urandom};
      b3.Select   = 2'($urandom_range(0, 3));
      b3.In_Valid = ($urandom_range(0, 3) != 0);
      b3.Q_Ready  = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset asserted mid-cycle while both instances hold two words
    b4.In_Data  = {32'h12345678, 32'hA5A5A5A5, 32'h22222222, 32'h11111111};
    b4.Q_Ready  = 1'b0; b4.In_Valid = 1'b0;
    b3.Q_Ready  = 1'b0; b3.In_Valid = 1'b0;
    tick();
    tick();
    b4.In_Valid = 1'b1; b4.Select = 2'd1;
    b3.In_Valid = 1'b1; b3.Select = 2'd1;
    tick();
    tick();
    chk("stall_full_rdy", 32'(b4.In_Ready), 32'h0);
    chk("stall_full_valid", 32'(b4.Q_Valid), 32'h1);
    #2 apply_reset_async();
    #1;
    chk("midrst_q_valid",  32'(b4.Q_Valid),  32'h0);
    chk("midrst_q",        b4.Q,             32'h0);
    chk("midrst_sel_err",  32'(b4.Sel_Err),  32'h0);
    chk("midrst_in_ready", 32'(b4.In_Ready), 32'h0);
    chk("midrst3_q_valid", 32'(b3.Q_Valid),  32'h0);
    b4.In_Valid = 1'b0; b4.Q_Ready = 1'b1;
    b3.In_Valid = 1'b0; b3.Q_Ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b0;
    tick();
    chk("postrst_in_ready", 32'(b4.In_Ready), 32'h1);
    chk("postrst_q_valid",  32'(b4.Q_Valid),  32'h0);
    repeat (3) tick();
    chk("postrst_no_emit",  32'(b4.Q_Valid),  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised N:1 word multiplexer with registered output and a valid/ready handshake on both sides.
- Successor to the combinational 2:1 datapath mux.
- Used on processor datapath paths that cross a pipeline stage, such as writeback source select and forwarding select.
- Contains a 2-entry skid buffer, so upstream sees a registered In_Ready and no combinational ready path passes through the block.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input words (>=2).
- SEL_W, $clog2(NUM_IN) (localparam), select field width.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- In_Data  input  NUM_IN*WIDTH  packed inputs; word i occupies [i*WIDTH +: WIDTH].
- Select  input  SEL_W  index of the word to forward; sampled together with In_Data.
- In_Valid  input  1  upstream offers In_Data/Select this cycle.
- In_Ready  output  1  block can accept this cycle; registered.
- Q  output  WIDTH  selected word; registered.
- Q_Valid  output  1  Q holds a valid word.
- Q_Ready  input  1  downstream accepts Q this cycle.
- Sel_Err  output  1  the word on Q came from an out-of-range Select (Select >= NUM_IN); travels with Q.

Behaviour:
- Reset (async, Reset=1):
  - Q=0, Q_Valid=0, Sel_Err=0.
  - In_Ready=0 while Reset is high; In_Ready=1 on the first Clk edge after Reset deasserts.
  - Skid buffer is emptied.
  - A transfer in flight when Reset asserts is dropped with no partial output.
- Transfers:
  - Accept on a Clk edge where In_Valid && In_Ready.
  - Emit on a Clk edge where Q_Valid && Q_Ready.
- Mux function:
  - sel_word = In_Data[Select*WIDTH +: WIDTH] when Select < NUM_IN.
  - Otherwise sel_word = 0 and err = 1.
  - The mux is evaluated at the accept edge only.
- State machine (occupancy):
  - EMPTY: Q_Valid=0. Accept -> ONE, with Q loaded and Q_Valid=1 at that edge. Latency from accept to Q_Valid is 1 cycle.
  - ONE: Q_Valid=1.
    - Accept and emit together -> ONE, Q takes the new word.
    - Accept only -> TWO, new word goes to the skid register and In_Ready goes 0 at that edge.
    - Emit only -> EMPTY.
  - TWO: In_Ready=0, so no accept is possible. Emit -> ONE, the skid word moves to Q and In_Ready returns to 1.
- Q, Select-derived data and Sel_Err are stable while Q_Valid=1 && Q_Ready=0. There is no bubble on a stall.
- Full throughput: one word per cycle sustained when Q_Ready=1 continuously.
- Ordering: strict FIFO order across Q and the skid register.
- In_Valid while In_Ready=0 is ignored. Upstream must hold In_Data/Select.
- When NUM_IN is not a power of two, out-of-range select codes are reachable. Each one yields Q=0 and Sel_Err=1 for exactly that word.

Optional Feature:
- Macro: PIPE_MUX_PARITY_EN.
- With the macro defined:
  - Adds output Q_Parity (1 bit), the even parity of Q (XOR of all Q bits).
  - Q_Parity is registered alongside Q and held in the skid register.
  - Reset value is 0.
  - Parity of an error word (Q=0) is 0.
- Without the macro: the port is absent and no parity logic is built.

Decomposition:
- Package pipe_mux_pkg holds:
  - the occupancy enum typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the default width constant (32).
- One sub-module, mux_sel_n: purely combinational indexed select with the out-of-range error flag. It is reused by the datapath.
- Skid/FSM logic stays in the top module.

Test Plan:
- Basic select:
  - Stimulus: NUM_IN=4, WIDTH=32, In_Data words {32'h11111111, 32'h22222222, 32'hA5A5A5A5, 32'h12345678}, Select=2, In_Valid=1, Q_Ready=1.
  - Required: next cycle Q=32'hA5A5A5A5, Q_Valid=1, Sel_Err=0.
- Stream:
  - Stimulus: Select=0,1,2,3 on consecutive cycles, Q_Ready held 1.
  - Required: Q=11111111, 22222222, A5A5A5A5, 12345678 on consecutive cycles, no gaps.
- Backpressure:
  - Stimulus: Q_Ready=0, offer Select=1 then Select=3.
  - Required: Q=22222222 held, In_Ready=0 after the second accept.
  - Then Q_Ready=1 gives 22222222 then 12345678 in order, and In_Ready=1 again.
- Out-of-range:
  - Stimulus: NUM_IN=3, Select=3.
  - Required: Q=0, Sel_Err=1 for one word only; the following Select=0 gives Sel_Err=0.
- Reset mid-stall:
  - Stimulus: state TWO, assert Reset asynchronously mid-cycle.
  - Required: Q_Valid, Q and Sel_Err go 0 immediately; after release, In_Ready=1 on the first Clk edge and the buffered words are never emitted.
- Parity (PIPE_MUX_PARITY_EN):
  - Stimulus: select 32'h00000007, then 32'h00000003.
  - Required: Q_Parity=1, then Q_Parity=0.
